// File: rtl/hub75_row_capture_pkg.sv
// Shared definitions for the row-scan panel interface: capture states,
// width helpers and the idle levels the driver parks the bus at.
package hub75_row_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCHED = 2'd1,
    ST_ON      = 2'd2
  } state_t;

  localparam logic LAT_IDLE  = 1'b1;
  localparam logic OE_IDLE   = 1'b1;
  localparam logic OCLK_IDLE = 1'b0;

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int on_w(input int row_post);
    return $clog2(row_post) + 1;
  endfunction

endpackage

// File: rtl/hub75_row_capture_edge_sampler.sv
// Registers the panel pins once and derives the edge strobes the capture
// logic acts on. Previous samples start at idle levels so reset release is quiet.
module hub75_edge_sampler
  import hub75_row_capture_pkg::*;
#(
  parameter int RW    = 3,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oclk,
  input  logic             lat,
  input  logic             oe,
  input  logic [RW-1:0]    row,
  input  logic [LANES-1:0] data,
  output logic             oe_lvl,
  output logic [RW-1:0]    row_lvl,
  output logic [LANES-1:0] data_lvl,
  output logic             oclk_rise,
  output logic             lat_fall,
  output logic             oe_rise
);

  logic oclk_q, lat_q, oe_q;
  logic oclk_p, lat_p, oe_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      oclk_q   <= OCLK_IDLE;
      lat_q    <= LAT_IDLE;
      oe_q     <= OE_IDLE;
      oclk_p   <= OCLK_IDLE;
      lat_p    <= LAT_IDLE;
      oe_p     <= OE_IDLE;
      row_lvl  <= '0;
      data_lvl <= '0;
    end else begin
      oclk_q   <= oclk;
      lat_q    <= lat;
      oe_q     <= oe;
      oclk_p   <= oclk_q;
      lat_p    <= lat_q;
      oe_p     <= oe_q;
      row_lvl  <= row;
      data_lvl <= data;
    end
  end

  assign oe_lvl    = oe_q;
  assign oclk_rise = oclk_q & ~oclk_p;
  assign lat_fall  = ~lat_q & lat_p;
  assign oe_rise   = oe_q & ~oe_p;

endmodule

// File: rtl/hub75_row_capture.sv
// Panel-side receiver: rebuilds each latched row, times its /OE window and
// emits one record per displayed row.
module hub75_row_capture
  import hub75_row_capture_pkg::*;
#(
  parameter  int ROWS     = 8,
  parameter  int COLUMNS  = 32,
  parameter  int LANES    = 1,
  parameter  int ROW_POST = 32,
  localparam int RW       = row_w(ROWS),
  localparam int OW       = on_w(ROW_POST),
  localparam int BW       = COLUMNS * LANES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_oclk,
  input  logic             i_lat,
  input  logic             i_oe,
  input  logic [RW-1:0]    i_row,
  input  logic [LANES-1:0] i_data,
  output logic             o_row_valid,
  output logic [RW-1:0]    o_row_addr,
  output logic [BW-1:0]    o_row_bits,
  output logic [OW-1:0]    o_on_cycles,
  output logic             o_len_err,
  output logic             o_overrun,
  output logic             o_frame_done
);

  localparam int CW = $clog2(COLUMNS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(COLUMNS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(COLUMNS + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic             oe_q;
  logic [RW-1:0]    row_q;
  logic [LANES-1:0] data_q;
  logic             oclk_rise, lat_fall, oe_rise;

  hub75_edge_sampler #(.RW(RW), .LANES(LANES)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .oclk     (i_oclk),
    .lat      (i_lat),
    .oe       (i_oe),
    .row      (i_row),
    .data     (i_data),
    .oe_lvl   (oe_q),
    .row_lvl  (row_q),
    .data_lvl (data_q),
    .oclk_rise(oclk_rise),
    .lat_fall (lat_fall),
    .oe_rise  (oe_rise)
  );

  state_t        state, state_n;
  logic [BW-1:0] shreg, shreg_n, lat_bits;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic [RW-1:0] lat_row;
  logic          len_flag;
  logic [OW-1:0] on_cnt, on_n, on_inc, emit_on;
  logic          emit, load, overrun;

  // A latch in the same sample as the last shift must see that shift.
  assign shreg_n = oclk_rise ? {data_q, shreg[BW-1:LANES]} : shreg;
  assign cnt_n   = (oclk_rise && bit_cnt != CNT_MAX) ? bit_cnt + 1'b1 : bit_cnt;
  assign on_inc  = (on_cnt == '1) ? on_cnt : on_cnt + 1'b1;

  always_comb begin
    state_n = state;
    on_n    = on_cnt;
    emit_on = on_cnt;
    emit    = 1'b0;
    load    = 1'b0;
    overrun = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lat_fall) begin
          load    = 1'b1;
          state_n = ST_LATCHED;
        end
      end
      ST_LATCHED: begin
        if (lat_fall) begin
          load    = 1'b1;
          overrun = 1'b1;
        end else if (!oe_q) begin
          on_n    = OW'(1);
          state_n = ST_ON;
        end
      end
      ST_ON: begin
        if (lat_fall) begin
          // Back-to-back rows: close this record and arm the next one.
          emit    = 1'b1;
          load    = 1'b1;
          emit_on = oe_q ? on_cnt : on_inc;
          on_n    = '0;
          state_n = ST_LATCHED;
        end else if (oe_rise) begin
          emit    = 1'b1;
          on_n    = '0;
          state_n = ST_IDLE;
        end else if (!oe_q) begin
          on_n = on_inc;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      on_cnt       <= '0;
      lat_bits     <= '0;
      lat_row      <= '0;
      len_flag     <= 1'b0;
      o_row_valid  <= 1'b0;
      o_row_addr   <= '0;
      o_row_bits   <= '0;
      o_on_cycles  <= '0;
      o_len_err    <= 1'b0;
      o_overrun    <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_n;
      on_cnt       <= on_n;
      shreg        <= shreg_n;
      bit_cnt      <= lat_fall ? '0 : cnt_n;
      o_row_valid  <= emit;
      o_overrun    <= overrun;
      o_frame_done <= emit && (lat_row == ROW_LAST);
      if (load) begin
        lat_bits <= shreg_n;
        lat_row  <= row_q;
        len_flag <= (cnt_n != CNT_FULL);
      end
      if (emit) begin
        o_row_addr  <= lat_row;
        o_row_bits  <= lat_bits;
        o_on_cycles <= emit_on;
        o_len_err   <= len_flag;
      end
    end
  end

endmodule

// File: tb/tb_hub75_row_capture.sv
// Drives the panel bus like the row driver would; expected records go into
// a queue and a negedge monitor pops and compares each emitted record.
module tb_hub75_row_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_oclk = 1'b0, i_lat = 1'b1, i_oe = 1'b1;
  logic [2:0]  i_row = '0;
  logic [0:0]  i_data = '0;
  logic        o_row_valid, o_len_err, o_overrun, o_frame_done;
  logic [2:0]  o_row_addr;
  logic [31:0] o_row_bits;
  logic [5:0]  o_on_cycles;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] bits;
    logic [5:0]  on;
    logic        len;
    logic        fd;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   overruns = 0;

  hub75_row_capture dut (
    .clk         (clk),
    .rst         (rst),
    .i_oclk      (i_oclk),
    .i_lat       (i_lat),
    .i_oe        (i_oe),
    .i_row       (i_row),
    .i_data      (i_data),
    .o_row_valid (o_row_valid),
    .o_row_addr  (o_row_addr),
    .o_row_bits  (o_row_bits),
    .o_on_cycles (o_on_cycles),
    .o_len_err   (o_len_err),
    .o_overrun   (o_overrun),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (o_overrun) overruns++;
    if (o_frame_done && !o_row_valid) chk("frame_done_without_valid", 1, 0);
    if (o_row_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", 1, 0);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("row_addr", o_row_addr, e.addr);
        chk("row_bits", o_row_bits, e.bits);
        chk("on_cycles", o_on_cycles, e.on);
        chk("len_err", o_len_err, e.len);
        chk("frame_done", o_frame_done, e.fd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      i_data = w[i];
      i_oclk = 1'b1;
      cyc();
      i_oclk = 1'b0;
      cyc();
    end
  endtask

  // Row address is valid only around the latch; garbage elsewhere.
  task automatic latch(input logic [2:0] row);
    i_row = row;
    cyc();
    i_lat = 1'b0;
    cyc();
    i_lat = 1'b1;
    i_row = ~row;
    cyc();
  endtask

  task automatic oe_on(input int n);
    i_oe = 1'b0;
    repeat (n) cyc();
    i_oe = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic expect_rec(input logic [2:0] a, input logic [31:0] b,
                            input logic [5:0] on, input logic len, input logic fd);
    rec_t r;
    r.addr = a; r.bits = b; r.on = on; r.len = len; r.fd = fd;
    exp_q.push_back(r);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, o_row_valid, 0);
    chk({tag, "_bits"}, o_row_bits, 0);
    chk({tag, "_on"}, o_on_cycles, 0);
    chk({tag, "_addr"}, o_row_addr, 0);
  endtask

  logic [31:0] fb [8] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_0000, 32'h0000_FFFF,
                          32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8000_0001, 32'h5A5A_A5A5};

  initial begin
    repeat (3) cyc();
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) cyc();

    // 1: full row 3
    expect_rec(3'd3, 32'hA5A5_0F0F, 6'd32, 1'b0, 1'b0);
    shift(32'hA5A5_0F0F, 32); latch(3'd3); oe_on(32);

    // 2: short row (31 shifts leaves previous bit31 at column 0), then a good one
    expect_rec(3'd3, 32'h4B4A_1E1F, 6'd4, 1'b1, 1'b0);
    shift(32'hA5A5_0F0F, 31); latch(3'd3); oe_on(4);
    expect_rec(3'd3, 32'hA5A5_0F0F, 6'd4, 1'b0, 1'b0);
    shift(32'hA5A5_0F0F, 32); latch(3'd3); oe_on(4);

    // 3: overrun, row 1 discarded
    expect_rec(3'd2, 32'h2222_2222, 6'd5, 1'b0, 1'b0);
    shift(32'h1111_1111, 32); latch(3'd1);
    shift(32'h2222_2222, 32); latch(3'd2); oe_on(5);

    // 4: minimum and saturated on-time
    expect_rec(3'd4, 32'h0000_FFFF, 6'd1, 1'b0, 1'b0);
    shift(32'h0000_FFFF, 32); latch(3'd4); oe_on(1);
    expect_rec(3'd5, 32'hDEAD_BEEF, 6'd63, 1'b0, 1'b0);
    shift(32'hDEAD_BEEF, 32); latch(3'd5); oe_on(100);

    // 5: reset mid-row drops partial shifts
    shift(32'hFFFF_FFFF, 10);
    rst = 1'b1;
    repeat (3) cyc();
    chk_outputs_zero("midrow_reset");
    rst = 1'b0;
    repeat (3) cyc();
    chk("post_reset_valid", o_row_valid, 0);
    expect_rec(3'd0, 32'h1234_5678, 6'd3, 1'b0, 1'b0);
    shift(32'h1234_5678, 32); latch(3'd0); oe_on(3);

    // 6: full frame, rows 0..7
    for (int r = 0; r < 8; r++) begin
      expect_rec(3'(r), fb[r], 6'd6, 1'b0, r == 7);
      shift(fb[r], 32); latch(3'(r)); oe_on(6);
    end

    repeat (10) cyc();
    chk("records_outstanding", exp_q.size(), 0);
    chk("overrun_pulses", overruns, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
